// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words and writes them sequentially to instruction memory
//   clk, rst_n              clock, async active-low reset
//   start, base_addr, count load request; base address and word count sampled when accepted in IDLE
//   in_valid/in_ready       field bundle handshake (in_opcode, in_rd, in_rs1, in_rs2, in_imm)
//   mem_we/addr/wdata       registered memory write port, mem_wdata bit 0 is the MSB
//   busy, done              load in progress; one-cycle completion pulse
//   err, err_addr           sticky immediate range error and address of the first offending word
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:31]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);
  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] remain;
  logic hs, is_i10, is_i5, oor;
  logic [31:0] word;
  always_comb begin
    in_ready = state == RUN;
    busy = state != IDLE;
    done = state == LAST;
    hs = in_valid && state == RUN;
    is_i10 = in_opcode == 5'b11000;
    is_i5 = in_opcode inside {5'b11001, 5'b10001, 5'b10011, 5'b10010};
    oor = is_i10 ? |in_imm[31:10] : is_i5 ? |in_imm[31:5] : 1'b0;
    // word[31] lands on mem_wdata[0], so fields are listed MSB first
    word = is_i10 ? {in_opcode, in_rd, in_imm[9:0], 12'b0}
                  : {in_opcode, in_rd, in_rs1, is_i5 ? in_imm[4:0] : in_rs2, 12'b0};
    state_nx = state;
    if (state == IDLE && start) state_nx = count == '0 ? LAST : RUN;
    else if (hs && remain == 1) state_nx = LAST;
    else if (state == LAST) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      remain <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_nx;
      mem_we <= hs;
      if (state == IDLE && start) begin
        ptr <= base_addr;
        remain <= count;
        err <= 1'b0;
        err_addr <= '0;
      end
      if (hs) begin
        ptr <= ptr + 1'b1;
        remain <= remain - 1'b1;
        mem_addr <= ptr;
        mem_wdata <= word;
        if (oor && !err) begin
          err <= 1'b1;
          err_addr <= ptr;
        end
      end
    end
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader for the SIMD AES core. It takes decoded instruction fields (opcode, register indices, full-width immediate) over a valid/ready stream and packs them into 32-bit instruction words. Each word is written sequentially into instruction memory from a programmable base address. It is the write-side counterpart of the decode-stage immediate generator, and the immediate placement and zero-extension rules here are the inverse of that decoder's.

## Interface
- ADDR_W, 8, instruction memory address width; also the width of `base_addr`.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored while `busy`=1.
- base_addr  in  ADDR_W  first write address, sampled on an accepted `start`.
- count  in  ADDR_W+1  number of words to load, sampled on an accepted `start`; 0 is legal.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  5  opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  unsigned immediate.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  [0:31]  encoded word; bit 0 is the MSB.
- busy  out  1  load in progress.
- done  out  1  single-cycle completion pulse.
- err  out  1  sticky immediate range error.
- err_addr  out  ADDR_W  address of the first word that raised `err`.

## Operation
- **Encoding.** All unlisted bits are 0. Bit 0 of the word is the MSB.
  - Opcode 11000 (I10 format): [0:4] op, [5:9] rd, [10:19] imm[9:0].
  - Opcodes 11001, 10001, 10011, 10010 (I5 format): [0:4] op, [5:9] rd, [10:14] rs1, [15:19] imm[4:0].
  - All other opcodes (R format): [0:4] op, [5:9] rd, [10:14] rs1, [15:19] rs2. `in_imm` is ignored.
- **Range check.**
  - I10 requires in_imm < 1024. I5 requires in_imm < 32.
  - A violating word is still written, with the immediate truncated to its field width.
  - On the first violation since `start`, `err` is set and `err_addr` records that word's address.
  - `err` and `err_addr` clear only on an accepted `start`.
- **FSM states:** IDLE, RUN, LAST.
  - IDLE: `start` loads the address pointer from `base_addr` and the remaining counter from `count`, and clears `err`/`err_addr`.
    - count > 0 -> RUN.
    - count = 0 -> LAST with no write pending.
  - RUN: `in_ready`=1. Each handshake (in_valid & in_ready) registers the encoded word and the current address, increments the pointer, and decrements the remaining counter.
    - If the accepted word is the final one -> LAST.
    - Otherwise stay in RUN.
  - LAST: `done`=1 for this one cycle, `in_ready`=0, then -> IDLE.
- **Address pointer.** Wraps modulo 2^ADDR_W with no error. For example, base 0xFF with count 2 writes 0xFF, then 0x00.
- **Reset** (asynchronous, any state, including mid-load) forces:
  - state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, err_addr=0;
  - the pointer and counter to 0.
  - The partially loaded memory image is abandoned; no further writes occur.

## Timing
- A bundle accepted in cycle N appears as `mem_we`=1 with its `mem_addr`/`mem_wdata` in cycle N+1. `mem_we` is high for exactly one cycle per word.
- Back-to-back handshakes give one write per cycle. Throughput is 1 word/cycle.
- The final word's write is presented in the same cycle as `done`=1 (the LAST state).
- For count=0, `done` pulses in the cycle after `start`, and no write occurs.
- `busy`=1 from the cycle after an accepted `start` through the `done` cycle inclusive.
- `in_ready` depends only on the state, never combinationally on `in_valid`.
- When `in_valid` is low in RUN, the pointer and counter hold and `mem_we`=0.
- `start` asserted while `busy`=1 has no effect.

## Test plan
- **Reset:** assert rst_n=0 mid-RUN -> all outputs 0 asynchronously; after release, state is IDLE and in_ready=0.
- **I10 encoding:** start base=0x10 count=1; bundle op=11000 rd=3 imm=0x2A5 -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xC0EA5000, done=1, err=0.
- **I5 and R encoding, back-to-back:** start base=0x00 count=2.
  - Bundle op=10001 rd=1 rs1=2 imm=7 -> 0x88447000 @0x00.
  - Next cycle, bundle op=00001 rd=4 rs1=5 rs2=6 -> 0x090A6000 @0x01.
  - done=1 in the second write cycle.
- **Range error:** start base=0x20 count=2.
  - Bundle op=10011 imm=40 -> word written with imm field 01000, err=1, err_addr=0x20.
  - Second bundle out of range -> err_addr stays 0x20.
  - Next accepted start clears err.
- **Wrap and stalls:** start base=0xFF count=3 with in_valid toggling 1,0,1,0,1 -> writes only in the cycles after handshakes, at 0xFF, 0x00, 0x01.
- **count=0 and start-while-busy:** start count=0 -> done one cycle later, no mem_we. During a load, a second start pulse -> ignored; base, count and err are unchanged.
